// File: rtl/ifu_prefetch_pkg.sv
// Shared defaults and constants for the instruction prefetch unit.
package ifu_prefetch_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 4;
   localparam int unsigned INST_STEP  = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally on rdata.
module ifu_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO is accepted when the head leaves in the same cycle.
   always_comb begin
      pop_ok  = pop && (count != '0);
      push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: credit-limited bus fetch into a PC-tagged buffer,
// with redirect flush and discard of responses still in flight at a jump.
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       DATA_W   = DATA_W_DEF,
   parameter int unsigned       DEPTH    = DEPTH_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_i,
   output logic              ibus_req_o,
   output logic [ADDR_W-1:0] ibus_addr_o,
   input  logic              ibus_gnt_i,
   input  logic              ibus_rvalid_i,
   input  logic [DATA_W-1:0] ibus_rdata_i,
   output logic              ifu_valid_o,
   output logic [ADDR_W-1:0] ifu_pc_o,
   output logic [DATA_W-1:0] ifu_inst_data_o,
   input  logic              ifu_ready_i
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 2;

   logic [ADDR_W-1:0]        fetch_pc;
   logic [CNT_W-1:0]         discard;
   logic [CNT_W-1:0]         buf_count;
   logic [CNT_W-1:0]         out_count;
   logic [ADDR_W+DATA_W-1:0] buf_head;
   logic [ADDR_W-1:0]        inflight_pc;
   logic [SUM_W-1:0]         credits_used;
   logic                     grant;
   logic                     rsp_keep;
   logic                     buf_pop;

   always_comb begin
      credits_used = SUM_W'(buf_count) + SUM_W'(out_count) + SUM_W'(discard);
      ibus_req_o   = !rst && !jump_i && !hold_i && (credits_used < SUM_W'(DEPTH));
      ibus_addr_o  = fetch_pc;
      grant        = ibus_req_o && ibus_gnt_i;
      rsp_keep     = ibus_rvalid_i && !jump_i && (discard == '0);
      ifu_valid_o  = !rst && (buf_count != '0);
      buf_pop      = ifu_valid_o && ifu_ready_i && !jump_i;
      ifu_pc_o        = ifu_valid_o ? buf_head[ADDR_W+DATA_W-1:DATA_W] : '0;
      ifu_inst_data_o = ifu_valid_o ? buf_head[DATA_W-1:0] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst)          fetch_pc <= RESET_PC;
      else if (jump_i)  fetch_pc <= jump_addr_i & ~ADDR_W'(3);
      else if (grant)   fetch_pc <= fetch_pc + ADDR_W'(INST_STEP);
   end

   // Earlier pending discards still arrive after a second jump, so they are
   // carried over; a response landing in the jump cycle is already gone.
   always_ff @(posedge clk) begin
      if (rst)
         discard <= '0;
      else if (jump_i)
         discard <= CNT_W'(SUM_W'(out_count) + SUM_W'(discard) - SUM_W'(ibus_rvalid_i));
      else if (ibus_rvalid_i && (discard != '0))
         discard <= discard - CNT_W'(1);
   end

   ifu_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk   (clk),
      .rst   (rst),
      .flush (jump_i),
      .push  (rsp_keep),
      .wdata ({inflight_pc, ibus_rdata_i}),
      .pop   (buf_pop),
      .rdata (buf_head),
      .count (buf_count)
   );

   ifu_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_inflight (
      .clk   (clk),
      .rst   (rst),
      .flush (jump_i),
      .push  (grant),
      .wdata (fetch_pc),
      .pop   (rsp_keep),
      .rdata (inflight_pc),
      .count (out_count)
   );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order, one-cycle-latency bus model.
module tb_ifu_prefetch;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              jump;
   logic [ADDR_W-1:0] jump_addr;
   logic              hold;
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              valid;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] inst;
   logic              ready;
   logic              rsp_en;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int req_cnt = 0;
   int first_grant_cyc;
   int first_valid_cyc;
   int rc;

   logic [ADDR_W-1:0] grant_log [$];
   logic [ADDR_W-1:0] pop_pc [$];
   logic [DATA_W-1:0] pop_data [$];
   logic [ADDR_W-1:0] pend_addr [$];
   int                pend_cyc [$];

   always #5 clk = ~clk;

   ifu_prefetch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .jump_i          (jump),
      .jump_addr_i     (jump_addr),
      .hold_i          (hold),
      .ibus_req_o      (req),
      .ibus_addr_o     (addr),
      .ibus_gnt_i      (gnt),
      .ibus_rvalid_i   (rvalid),
      .ibus_rdata_i    (rdata),
      .ifu_valid_o     (valid),
      .ifu_pc_o        (pc),
      .ifu_inst_data_o (inst),
      .ifu_ready_i     (ready)
   );

   function automatic logic [DATA_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      grant_log.delete();
      pop_pc.delete();
      pop_data.delete();
      first_grant_cyc = -1;
      first_valid_cyc = -1;
   endtask

   // Called at a negedge with this cycle's inputs set; returns at the next negedge.
   task automatic cycle();
      if (rsp_en && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
         rvalid = 1'b1;
         rdata  = inst_of(pend_addr[0]);
         pend_addr.delete(0);
         pend_cyc.delete(0);
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
      end
      #1;
      if (req) req_cnt++;
      if (req && gnt) begin
         grant_log.push_back(addr);
         pend_addr.push_back(addr);
         pend_cyc.push_back(cyc);
         if (first_grant_cyc < 0) first_grant_cyc = cyc;
      end
      if (valid) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (ready && !jump) begin
            pop_pc.push_back(pc);
            pop_data.push_back(inst);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; jump = 1'b0; jump_addr = '0; hold = 1'b0;
      gnt = 1'b0; ready = 1'b0; rsp_en = 1'b0;
      rvalid = 1'b0; rdata = '0;
      pend_addr.delete();
      pend_cyc.delete();
      #1;
      check_eq("rst_req",   64'(req),   64'd0);
      check_eq("rst_valid", 64'(valid), 64'd0);
      check_eq("rst_pc",    64'(pc),    64'd0);
      check_eq("rst_inst",  64'(inst),  64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic check_pop_data(input string tag);
      for (int i = 0; i < pop_pc.size(); i++)
         check_eq(tag, 64'(pop_data[i]), 64'(inst_of(pop_pc[i])));
   endtask

   initial begin
      rst = 1'b1; jump = 1'b0; jump_addr = '0; hold = 1'b0;
      gnt = 1'b0; ready = 1'b0; rsp_en = 1'b0; rvalid = 1'b0; rdata = '0;
      clear_logs();
      @(negedge clk);

      // Streaming from reset
      do_reset();
      gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
      repeat (10) cycle();
      check_eq("a_grants",  64'(grant_log.size() >= 4), 64'd1);
      check_eq("a_addr0",   64'(grant_log[0]), 64'h0);
      check_eq("a_addr1",   64'(grant_log[1]), 64'h4);
      check_eq("a_addr2",   64'(grant_log[2]), 64'h8);
      check_eq("a_addr3",   64'(grant_log[3]), 64'hC);
      check_eq("a_latency", 64'(first_valid_cyc - first_grant_cyc), 64'd2);
      check_eq("a_pops",    64'(pop_pc.size() >= 4), 64'd1);
      check_eq("a_pop0",    64'(pop_pc[0]), 64'h0);
      check_eq("a_pop3",    64'(pop_pc[3]), 64'hC);
      check_pop_data("a_data");

      // Decode stalled: credits cap the buffer at DEPTH
      do_reset();
      gnt = 1'b1; ready = 1'b0; rsp_en = 1'b1;
      repeat (12) cycle();
      check_eq("b_grants",  64'(grant_log.size()), 64'd4);
      check_eq("b_req_low", 64'(req), 64'd0);
      check_eq("b_valid",   64'(valid), 64'd1);
      check_eq("b_head_pc", 64'(pc), 64'h0);
      ready = 1'b1;
      repeat (4) cycle();
      check_eq("b_resume_n",  64'(grant_log.size() >= 5), 64'd1);
      check_eq("b_resume",    64'(grant_log[4]), 64'h10);
      check_eq("b_pop0",      64'(pop_pc[0]), 64'h0);
      check_eq("b_pop3",      64'(pop_pc[3]), 64'hC);
      check_pop_data("b_data");

      // Jump with two responses outstanding
      do_reset();
      gnt = 1'b1; ready = 1'b0; rsp_en = 1'b0;
      repeat (2) cycle();
      gnt = 1'b0;
      repeat (2) cycle();
      check_eq("c_outstanding", 64'(grant_log.size()), 64'd2);
      jump = 1'b1; jump_addr = 32'h0000_0103;
      rc = req_cnt;
      cycle();
      check_eq("c_req_in_jump", 64'(req_cnt - rc), 64'd0);
      jump = 1'b0; gnt = 1'b1; rsp_en = 1'b1; ready = 1'b1;
      clear_logs();
      repeat (12) cycle();
      check_eq("c_addr0", 64'(grant_log[0]), 64'h100);
      check_eq("c_addr1", 64'(grant_log[1]), 64'h104);
      check_eq("c_pops",  64'(pop_pc.size() >= 2), 64'd1);
      check_eq("c_pop0",  64'(pop_pc[0]), 64'h100);
      check_pop_data("c_data");

      // Response in the same cycle as the jump
      do_reset();
      gnt = 1'b1; ready = 1'b1; rsp_en = 1'b0;
      repeat (3) cycle();
      gnt = 1'b0;
      cycle();
      jump = 1'b1; jump_addr = 32'h0000_0200; rsp_en = 1'b1;
      cycle();
      check_eq("d_rsp_in_jump", 64'(pend_addr.size()), 64'd2);
      jump = 1'b0; rsp_en = 1'b0; gnt = 1'b1;
      clear_logs();
      repeat (6) cycle();
      check_eq("d_credit_grants", 64'(grant_log.size()), 64'd2);
      check_eq("d_addr0", 64'(grant_log[0]), 64'h200);
      check_eq("d_addr1", 64'(grant_log[1]), 64'h204);
      rsp_en = 1'b1;
      repeat (10) cycle();
      check_eq("d_pops", 64'(pop_pc.size() >= 2), 64'd1);
      check_eq("d_pop0", 64'(pop_pc[0]), 64'h200);
      check_eq("d_pop1", 64'(pop_pc[1]), 64'h204);
      check_pop_data("d_data");

      // Fetch address wrap-around
      do_reset();
      jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
      cycle();
      jump = 1'b0; gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
      clear_logs();
      repeat (5) cycle();
      check_eq("e_addr0", 64'(grant_log[0]), 64'hFFFF_FFFC);
      check_eq("e_addr1", 64'(grant_log[1]), 64'h0);
      check_eq("e_pop0",  64'(pop_pc[0]), 64'hFFFF_FFFC);
      check_pop_data("e_data");

      // hold_i blocks requests but not responses or pops
      do_reset();
      gnt = 1'b1; ready = 1'b1; rsp_en = 1'b0;
      repeat (2) cycle();
      hold = 1'b1; rsp_en = 1'b1;
      clear_logs();
      rc = req_cnt;
      repeat (5) cycle();
      check_eq("f_hold_grants", 64'(grant_log.size()), 64'd0);
      check_eq("f_hold_req",    64'(req_cnt - rc), 64'd0);
      check_eq("f_hold_pops",   64'(pop_pc.size()), 64'd2);
      check_eq("f_pop0",        64'(pop_pc[0]), 64'h0);
      check_eq("f_pop1",        64'(pop_pc[1]), 64'h4);
      hold = 1'b0;
      repeat (3) cycle();
      check_eq("f_resume", 64'(grant_log[0]), 64'h8);
      check_pop_data("f_data");

      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
